butterfly_pipe: RTL
===================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of every real/imag sample and twiddle component, two's complement.
REQ-002 SHALL have parameter Q, default 8: fractional bits of all operands and results; 0 < Q < DATA_WIDTH.
REQ-003 SHALL have parameter ROUND, default 1: 0 = truncate product, 1 = round-half-up (add 2^(Q-1) before dropping Q LSBs).
REQ-004 SHALL have parameter SAT, default 1: 0 = wrap on overflow, 1 = saturate to 2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1).
REQ-005 Ports: clk  in  1  clock; one clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid; in_ready  out  1  block accepts beat.
REQ-008 in1_r, in1_i, in2_r, in2_i, w_r, w_i  in  DATA_WIDTH each  operands A, B, twiddle W.
REQ-009 inv  in  1  per-beat: use conj(W) (inverse transform).
REQ-010 scale  in  1  per-beat: divide both outputs by 2 (arithmetic shift, ROUND rule applied).
REQ-011 out_valid  out  1; out_ready  in  1; out1_r, out1_i, out2_r, out2_i  out  DATA_WIDTH each.
REQ-012 ovf  out  1  sticky overflow flag; ovf_clr  in  1  clears ovf.

Function
REQ-013 SHALL compute P = B*W (or B*conj(W) if inv), out1 = A+P, out2 = A-P, each optionally /2.
REQ-014 Products SHALL be full 2*DATA_WIDTH signed; P_r = Br*Wr - Bi*Wi', P_i = Br*Wi' + Bi*Wr (Wi' = -Wi if inv), summed at 2*DATA_WIDTH+1 bits before rounding/narrowing.
REQ-015 Pipeline SHALL be 3 stages: S1 register 4 products + A + flags; S2 combine, round, shift by Q, saturate/wrap to DATA_WIDTH+1 bits; S3 add/sub, optional scale, saturate/wrap to DATA_WIDTH.
REQ-016 Latency SHALL be exactly 3 clk from accepted beat to out_valid when out_ready held high; throughput 1 beat/clk.
REQ-017 Beat accepted iff in_valid & in_ready; output consumed iff out_valid & out_ready.
REQ-018 Stall rule: advance = out_ready | ~out_valid; in_ready = advance; when advance=0 every stage register SHALL hold (no bubble collapse required).
REQ-019 Outputs and out_valid SHALL stay stable while out_valid & ~out_ready.
REQ-020 Per-stage valid bits SHALL propagate so bubbles pass through; out_valid = S3 valid.
REQ-021 -2^(DATA_WIDTH-1) * -2^(DATA_WIDTH-1) SHALL not wrap in the product stage (full width).
REQ-022 ovf SHALL set on the clk after any saturated/wrapped result leaves S3 on a valid beat (SAT=0 or 1); ovf_clr and a new overflow in the same cycle: set wins.
REQ-023 inv and scale SHALL be captured with their beat and travel the pipeline with it.

Reset
REQ-024 On rst: all stage valids, out_valid, ovf = 0; out1/out2 data = 0; in_ready = 1 the cycle after reset.
REQ-025 rst mid-operation SHALL discard all in-flight beats; no out_valid pulse from pre-reset beats.

Structure
REQ-026 Shared package bfly_pkg SHALL hold rounding and saturation helper functions and ROUND/SAT mode constants, reused by future FFT stages.
REQ-027 One sub-module cmul_pipe (complex multiply, S1-S2) is natural; add/sub/scale stage stays in butterfly_pipe.

Verification (DATA_WIDTH=16, Q=8, ROUND=1, SAT=1)
REQ-028 A=(0x0100,0), B=(0x0200,0), W=(0x0100,0) -> 3 clk later out1=(0x0300,0), out2=(0xFF00,0).
REQ-029 B=(0x0100,0), W=(0,0xFF00): inv=0 -> P=(0,0xFF00); inv=1 -> P=(0,0x0100) (checked via A=0, out1=P).
REQ-030 A=(0x7F00,0), B=(0x0200,0), W=(0x0100,0) -> out1_r=0x7FFF, out2_r=0x7D00, ovf=1; ovf_clr -> ovf=0.
REQ-031 A=(0x0300,0), P=(0x0100,0), scale=1 -> out1=(0x0200,0), out2=(0x0100,0).
REQ-032 Stream 8 beats, out_ready=0 for 5 clk mid-stream -> in_ready=0 while full, outputs held, all 8 results in order, none lost/duplicated.
REQ-033 rst asserted with 3 beats in flight -> out_valid stays 0, next post-reset beat appears after exactly 3 clk.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared fixed-point helpers for radix-2 butterfly stages: rounding shift,
// range check and saturating/wrapping narrowing on a wide signed scratch type.
package bfly_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Arithmetic right shift by sh, optionally adding half an LSB first.
  function automatic calc_t round_shift(input calc_t x, input int sh, input int round_mode);
    calc_t bias;
    bias = '0;
    if (round_mode == ROUND_HALF_UP && sh > 0) bias = calc_t'(1) <<< (sh - 1);
    return (x + bias) >>> sh;
  endfunction

  function automatic logic fits(input calc_t x, input int w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    return (x <= hi) && (x >= lo);
  endfunction

  // Bring x into a w-bit signed range; the caller keeps the low w bits.
  function automatic calc_t narrow(input calc_t x, input int w, input int sat_mode);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    if (fits(x, w)) return x;
    if (sat_mode == SAT_CLAMP) return (x < 0) ? lo : hi;
    return (x <<< (CALC_W - w)) >>> (CALC_W - w);
  endfunction

endpackage

// File: rtl/butterfly_pipe_cmul.sv
// Two-stage pipelined complex multiply P = B*W (or B*conj(W)), with an opaque
// sideband that travels alongside each beat.
module cmul_pipe
  import bfly_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 8,
  parameter int ROUND      = 1,
  parameter int SAT        = 1,
  parameter int SB_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] b_r,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] w_r,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic                  inv,
  input  logic [SB_W-1:0]       sb_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH:0]   p_r,
  output logic [DATA_WIDTH:0]   p_i,
  output logic                  p_ovf,
  output logic [SB_W-1:0]       sb_out
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int SW  = PW + 1;
  localparam int PW1 = DATA_WIDTH + 1;

  logic                 s1_valid;
  logic                 s1_inv;
  logic [SB_W-1:0]      s1_sb;
  logic signed [PW-1:0] rr, ii, ri, ir;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (en) s1_valid <= in_valid;
  end

  // Full-width products: the most negative value squared still fits in PW bits.
  always_ff @(posedge clk) begin
    if (en) begin
      rr     <= PW'($signed(b_r)) * PW'($signed(w_r));
      ii     <= PW'($signed(b_i)) * PW'($signed(w_i));
      ri     <= PW'($signed(b_r)) * PW'($signed(w_i));
      ir     <= PW'($signed(b_i)) * PW'($signed(w_r));
      s1_inv <= inv;
      s1_sb  <= sb_in;
    end
  end

  logic signed [SW-1:0] sum_r, sum_i;
  calc_t                rnd_r, rnd_i;
  logic [PW1-1:0]       nar_r, nar_i;
  logic                 ovf_n;

  // Conjugating W flips the sign of every Wi term, so negate at the combine.
  always_comb begin
    sum_r = s1_inv ? (SW'(rr) + SW'(ii)) : (SW'(rr) - SW'(ii));
    sum_i = s1_inv ? (SW'(ir) - SW'(ri)) : (SW'(ri) + SW'(ir));
    rnd_r = round_shift(calc_t'(sum_r), Q, ROUND);
    rnd_i = round_shift(calc_t'(sum_i), Q, ROUND);
    nar_r = PW1'(narrow(rnd_r, PW1, SAT));
    nar_i = PW1'(narrow(rnd_i, PW1, SAT));
    ovf_n = !fits(rnd_r, PW1) || !fits(rnd_i, PW1);
  end

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else if (en) out_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p_r    <= nar_r;
      p_i    <= nar_i;
      p_ovf  <= ovf_n;
      sb_out <= s1_sb;
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: out1 = A + B*W, out2 = A - B*W, optional conj(W) and
// halving per beat, three-stage pipeline with a sticky overflow flag.
module butterfly_pipe
  import bfly_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 8,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1_r,
  input  logic [DATA_WIDTH-1:0] in1_i,
  input  logic [DATA_WIDTH-1:0] in2_r,
  input  logic [DATA_WIDTH-1:0] in2_i,
  input  logic [DATA_WIDTH-1:0] w_r,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic                  inv,
  input  logic                  scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out1_r,
  output logic [DATA_WIDTH-1:0] out1_i,
  output logic [DATA_WIDTH-1:0] out2_r,
  output logic [DATA_WIDTH-1:0] out2_i,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int SB_W = 2 * DATA_WIDTH + 1;

  // Handshake: a beat transfers on in_valid & in_ready, a result on
  // out_valid & out_ready. The whole pipe advances together whenever the
  // output register is empty or being drained; otherwise every stage holds.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  logic                  s2_valid;
  logic [DATA_WIDTH:0]   p_r, p_i;
  logic                  p_ovf;
  logic [SB_W-1:0]       s2_sb;
  logic                  s2_scale;
  logic [DATA_WIDTH-1:0] s2_a_r, s2_a_i;

  cmul_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q),
    .ROUND      (ROUND),
    .SAT        (SAT),
    .SB_W       (SB_W)
  ) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (in_valid),
    .b_r       (in2_r),
    .b_i       (in2_i),
    .w_r       (w_r),
    .w_i       (w_i),
    .inv       (inv),
    .sb_in     ({scale, in1_r, in1_i}),
    .out_valid (s2_valid),
    .p_r       (p_r),
    .p_i       (p_i),
    .p_ovf     (p_ovf),
    .sb_out    (s2_sb)
  );

  assign {s2_scale, s2_a_r, s2_a_i} = s2_sb;

  calc_t                 raw [4];
  calc_t                 adj [4];
  logic [DATA_WIDTH-1:0] res [4];
  logic                  add_ovf;

  always_comb begin
    raw[0]  = calc_t'($signed(s2_a_r)) + calc_t'($signed(p_r));
    raw[1]  = calc_t'($signed(s2_a_i)) + calc_t'($signed(p_i));
    raw[2]  = calc_t'($signed(s2_a_r)) - calc_t'($signed(p_r));
    raw[3]  = calc_t'($signed(s2_a_i)) - calc_t'($signed(p_i));
    add_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      adj[k] = s2_scale ? round_shift(raw[k], 1, ROUND) : raw[k];
      res[k] = DATA_WIDTH'(narrow(adj[k], DATA_WIDTH, SAT));
      if (!fits(adj[k], DATA_WIDTH)) add_ovf = 1'b1;
    end
  end

  logic s3_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out1_r    <= '0;
      out1_i    <= '0;
      out2_r    <= '0;
      out2_i    <= '0;
      s3_ovf    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= s2_valid;
        out1_r    <= res[0];
        out1_i    <= res[1];
        out2_r    <= res[2];
        out2_i    <= res[3];
        s3_ovf    <= s2_valid & (p_ovf | add_ovf);
      end
      // A clipped result raises the flag as it is consumed; setting beats clearing.
      ovf <= (ovf & ~ovf_clr) | (out_valid & out_ready & s3_ovf);
    end
  end

endmodule
